// File: rtl/weight_bus_loader_if.sv
// weight_bus_loader_if: load command, weight stream and weight write bus bundle
interface weight_bus_loader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 24
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [31:0]           cmd_base_addr;
    logic [CNT_WIDTH-1:0]  cmd_num_words;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] weight_data;
    logic [31:0]           weight_addr;
    logic                  weight_we;
    modport master (
        input  cmd_valid, cmd_base_addr, cmd_num_words, s_data, s_valid,
        output cmd_ready, s_ready, weight_data, weight_addr, weight_we
    );
    modport slave (
        output cmd_valid, cmd_base_addr, cmd_num_words, s_data, s_valid,
        input  cmd_ready, s_ready, weight_data, weight_addr, weight_we
    );
endinterface

// File: rtl/weight_bus_loader.sv
// weight_bus_loader: streams weight words onto the PE write bus, then drains before signalling done
module weight_bus_loader #(
    parameter int DATA_WIDTH   = 16,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_WIDTH    = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_abort,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [CNT_WIDTH-1:0] o_words_written,
    weight_bus_loader_if.master  bus
);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
    state_t                r_state;
    logic [31:0]           r_next_addr;
    logic [CNT_WIDTH-1:0]  r_remaining;
    logic [CNT_WIDTH-1:0]  r_words;
    logic [DW-1:0]         r_drain;
    logic                  r_we;
    logic [31:0]           r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_cmd_ready;
    logic                  w_s_ready;
    logic                  w_accept;
    logic                  w_cmd_accept;
    // abort blocks the beat offered in the same cycle, including the final one
    assign w_s_ready    = (r_state == LOAD) && (r_remaining != '0) && !i_abort;
    assign w_accept     = w_s_ready && bus.s_valid;
    assign w_cmd_accept = r_cmd_ready && bus.cmd_valid;
    assign bus.cmd_ready   = r_cmd_ready;
    assign bus.s_ready     = w_s_ready;
    assign bus.weight_we   = r_we;
    assign bus.weight_addr = r_addr;
    assign bus.weight_data = r_data;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_words_written = r_words;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_next_addr <= '0;
            r_remaining <= '0;
            r_words     <= '0;
            r_drain     <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cmd_ready <= 1'b1;
        end else begin
            r_we   <= w_accept;
            r_done <= 1'b0;
            if (w_accept) begin
                r_addr      <= r_next_addr;
                r_data      <= bus.s_data;
                r_next_addr <= r_next_addr + 32'd1;
                r_remaining <= r_remaining - 1'b1;
                r_words     <= r_words + 1'b1;
            end
            case (r_state)
                IDLE: if (w_cmd_accept) begin
                    r_next_addr <= bus.cmd_base_addr;
                    r_remaining <= bus.cmd_num_words;
                    r_words     <= '0;
                    r_drain     <= DW'(DRAIN_CYCLES);
                    r_busy      <= 1'b1;
                    r_cmd_ready <= 1'b0;
                    r_state     <= (bus.cmd_num_words == '0) ? DRAIN : LOAD;
                end
                LOAD: if (i_abort) begin
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end else if (w_accept && r_remaining == CNT_WIDTH'(1)) begin
                    r_state <= DRAIN;
                    r_drain <= DW'(DRAIN_CYCLES);
                end
                DRAIN: if (i_abort) begin
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end else if (r_drain == '0) begin
                    r_state <= DONE;
                    r_done  <= 1'b1;
                end else begin
                    r_drain <= r_drain - 1'b1;
                end
                DONE: begin
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_weight_bus_loader.sv
// tb_weight_bus_loader: random loads checked every cycle against a cycle-arithmetic model
module tb_weight_bus_loader;
    localparam int DW    = 16;
    localparam int CW    = 24;
    localparam int DRAIN = 4;
    logic clk, rst_n, abort, busy, done;
    logic [CW-1:0] words;
    int checks = 0, failures = 0, cyc = 0;
    weight_bus_loader_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus();
    weight_bus_loader #(.DATA_WIDTH(DW), .DRAIN_CYCLES(DRAIN), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .i_abort(abort), .o_busy(busy), .o_done(done),
        .o_words_written(words), .bus(bus)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    logic [31:0]   m_next, e_addr;
    logic [DW-1:0] e_data;
    logic [CW-1:0] m_words;
    bit m_busy, m_loading, e_we, acc, cacc;
    int m_left, m_done_cyc;
    logic [31:0] wq_addr[$];
    logic [DW-1:0] wq_data[$];
    int wq_cyc[$];
    int done_cnt = 0, done_cyc = -1, cmd_cyc = -1;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    // done is due DRAIN+2 cycles after the accepting cycle of the last beat, or of a zero-length command
    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_loading = 0; m_done_cyc = -1; m_words = '0;
            e_we = 0; e_addr = '0; e_data = '0; m_next = '0; m_left = 0;
            chk("rst_we", bus.weight_we, 0);
            chk("rst_addr", bus.weight_addr, 0);
            chk("rst_data", bus.weight_data, 0);
            chk("rst_done", done, 0);
            chk("rst_words", words, 0);
            chk("rst_cmd_ready", bus.cmd_ready, 1);
            chk("rst_s_ready", bus.s_ready, 0);
            chk("rst_busy", busy, 0);
        end else begin
            chk("we", bus.weight_we, e_we);
            chk("addr", bus.weight_addr, e_addr);
            chk("data", bus.weight_data, e_data);
            chk("done", done, cyc == m_done_cyc);
            chk("busy", busy, m_busy);
            chk("cmd_ready", bus.cmd_ready, !m_busy);
            chk("s_ready", bus.s_ready, m_loading && !abort);
            chk("words", words, m_words);
            if (bus.weight_we) begin
                wq_addr.push_back(bus.weight_addr);
                wq_data.push_back(bus.weight_data);
                wq_cyc.push_back(cyc);
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (bus.cmd_valid && bus.cmd_ready) cmd_cyc = cyc;
            acc  = m_loading && !abort && bus.s_valid;
            cacc = !m_busy && bus.cmd_valid;
            e_we = acc;
            if (m_busy && cyc == m_done_cyc) begin
                m_busy = 0; m_done_cyc = -1;
            end else if (m_busy && abort) begin
                m_busy = 0; m_loading = 0; m_done_cyc = -1;
            end
            if (acc) begin
                e_addr = m_next; e_data = bus.s_data;
                m_next++; m_words++; m_left--;
                if (m_left == 0) begin m_loading = 0; m_done_cyc = cyc + DRAIN + 2; end
            end
            if (cacc) begin
                m_busy = 1; m_next = bus.cmd_base_addr; m_words = '0;
                m_left = int'(bus.cmd_num_words);
                if (m_left > 0) m_loading = 1; else m_done_cyc = cyc + DRAIN + 2;
            end
        end
        cyc++;
    end
    task automatic tick();
        @(posedge clk); #1;
    endtask
    task automatic do_load(input logic [31:0] base, input int n, input int gap, input int pat,
                           input int abort_at, input bit drain_abort, input bit keep_cmd, input bit seq);
        int a, t;
        bit got, ab;
        a = 0; t = 0; got = 0;
        bus.cmd_valid = 1; bus.cmd_base_addr = base; bus.cmd_num_words = CW'(n);
        while (!got && t < 100) begin #1; got = bus.cmd_ready; tick(); t++; end
        chk("cmd_accept_timeout", got, 1);
        if (keep_cmd) bus.cmd_base_addr = base + 32'h1000; else bus.cmd_valid = 0;
        t = 0;
        while (got && a < n && t < 500) begin
            bus.s_valid = (pat != 0) ? ((t < 32) ? pat[t] : 1'b1) : ($urandom_range(99) >= gap);
            bus.s_data = seq ? DW'(16'h0101 + a) : DW'($urandom);
            ab = (a == abort_at);
            abort = ab;
            #1;
            if (bus.s_valid && bus.s_ready) a++;
            tick(); t++;
            if (ab) break;
        end
        chk("stream_timeout", t < 500, 1);
        bus.s_valid = 0; abort = 0;
        t = 0;
        while (t < 100) begin
            bus.s_valid = 1'($urandom_range(1)); bus.s_data = DW'($urandom);
            abort = drain_abort && (t == 1);
            #1;
            if (!busy) break;
            tick(); t++;
        end
        abort = 0; bus.s_valid = 0;
        chk("idle_timeout", t < 100, 1);
    endtask
    initial begin
        #400000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end
    initial begin
        int w0, d0;
        rst_n = 1; abort = 0;
        bus.cmd_valid = 0; bus.cmd_base_addr = '0; bus.cmd_num_words = '0;
        bus.s_valid = 0; bus.s_data = '0;
        #2 rst_n = 0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1;
        tick();
        chk("init_cmd_ready", bus.cmd_ready, 1);
        chk("init_busy", busy, 0);
        w0 = wq_addr.size();
        do_load(32'd23, 4, 0, 0, -1, 0, 0, 1);
        chk("basic_nwrites", wq_addr.size() - w0, 4);
        for (int i = 0; i < 4; i++) begin
            chk("basic_addr", wq_addr[w0+i], 32'd23 + i);
            chk("basic_data", wq_data[w0+i], 16'h0101 + i);
        end
        chk("basic_back_to_back", wq_cyc[w0+3] - wq_cyc[w0], 3);
        chk("basic_done_lat", done_cyc - wq_cyc[w0+3], 5);
        chk("basic_words", words, 4);
        w0 = wq_addr.size();
        do_load(32'h40, 3, 0, 25, -1, 0, 0, 0);
        chk("stall_nwrites", wq_addr.size() - w0, 3);
        chk("stall_gap", wq_cyc[w0+1] - wq_cyc[w0], 3);
        chk("stall_next", wq_cyc[w0+2] - wq_cyc[w0+1], 1);
        chk("stall_addr2", wq_addr[w0+2], 32'h42);
        w0 = wq_addr.size(); d0 = done_cnt;
        do_load(32'h77, 0, 0, 0, -1, 0, 0, 0);
        chk("zero_nwrites", wq_addr.size() - w0, 0);
        chk("zero_done_cnt", done_cnt - d0, 1);
        chk("zero_done_lat", done_cyc - cmd_cyc, 6);
        w0 = wq_addr.size(); d0 = done_cnt;
        do_load(32'h200, 10, 0, 0, 6, 0, 0, 0);
        chk("abort_nwrites", wq_addr.size() - w0, 6);
        chk("abort_words", words, 6);
        chk("abort_busy", busy, 0);
        chk("abort_cmd_ready", bus.cmd_ready, 1);
        chk("abort_no_done", done_cnt - d0, 0);
        do_load(32'h300, 3, 0, 0, 2, 0, 0, 0);
        chk("abort_last_words", words, 2);
        do_load(32'h100, 3, 0, 0, -1, 0, 1, 0);
        w0 = wq_addr.size();
        do_load(32'h1100, 3, 0, 0, -1, 0, 0, 0);
        chk("bp_second_addr0", wq_addr[w0], 32'h1100);
        chk("bp_second_addr2", wq_addr[w0+2], 32'h1102);
        d0 = done_cnt;
        bus.cmd_valid = 1; bus.cmd_base_addr = 32'h5000; bus.cmd_num_words = CW'(8);
        tick();
        bus.cmd_valid = 0; bus.s_valid = 1; bus.s_data = 16'hbeef;
        tick();
        chk("pre_rst_we", bus.weight_we, 1);
        rst_n = 0;
        #1;
        chk("async_rst_we", bus.weight_we, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_cmd_ready", bus.cmd_ready, 1);
        bus.s_valid = 0;
        tick(); tick();
        #2 rst_n = 1;
        tick();
        repeat (8) tick();
        chk("rst_no_done", done_cnt - d0, 0);
        for (int i = 0; i < 14; i++) begin
            int n, ab;
            n = $urandom_range(0, 12);
            ab = (n > 0 && $urandom_range(3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            do_load($urandom, n, $urandom_range(0, 60), 0, ab, $urandom_range(4) == 0, 0, 0);
        end
        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
